// File: rtl/bounce_pkg.sv
// Shared definitions for the bounce generator: FSM state encoding, LFSR
// geometry, feedback taps and default seed, plus the LFSR feedback function.
package bounce_pkg;

  typedef enum logic [2:0] {
    IDLE_LOW,
    BOUNCE_RISE,
    SETTLE_HIGH,
    STABLE_HIGH,
    BOUNCE_FALL,
    SETTLE_LOW
  } state_t;

  localparam int             LFSR_W        = 8;
  // x^8 + x^6 + x^5 + x^4 + 1 -> state bits 7,5,4,3 feed the XOR
  localparam logic [LFSR_W-1:0] LFSR_TAPS     = 8'hB8;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 8'hA5;

  function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/bounce_lfsr.sv
// 8-bit Fibonacci LFSR that steps only when adv is high.
// Ports:
//   clk   - clock, rising edge
//   clr   - asynchronous active-low reset, loads SEED
//   adv   - advance enable, one step per cycle when high
//   state - current LFSR contents
module bounce_lfsr
  import bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_SEED_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              adv,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr)     state <= SEED;
    else if (adv) state <= {state[LFSR_W-2:0], lfsr_fb(state)};
  end

endmodule

// File: rtl/bounce_generator.sv
// Bouncy push-button emulator. A requested level change is turned into a
// burst of 2*GLITCH_PAIRS+1 toggles with pseudo-random spacing, followed by
// a settle period at the final level.
// Ports:
//   clk         - clock, rising edge
//   clr         - asynchronous active-low reset
//   press_req   - requested button level (sampled only when stable)
//   button_out  - emulated bouncy button level (registered)
//   busy        - high during bounce and settle phases
//   rise_count  - count of 0->1 edges on button_out, glitches included
//   press_count - count of completed clean presses
module bounce_generator
  import bounce_pkg::*;
#(
  parameter int                N            = 4,
  parameter int                GLITCH_PAIRS = 3,
  parameter int                MIN_GAP      = 4,
  parameter int                GAP_BITS     = 4,
  parameter int                SETTLE       = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_SEED_DEF
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         press_req,
  output logic         button_out,
  output logic         busy,
  output logic [N-1:0] rise_count,
  output logic [N-1:0] press_count
);

  localparam int TOGGLES = 2 * GLITCH_PAIRS + 1;
  localparam int GAP_W   = $clog2(MIN_GAP + 2**GAP_BITS);
  localparam int TOG_W   = $clog2(TOGGLES + 1);
  localparam int SET_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [LFSR_W-1:0] GAP_MASK = LFSR_W'((1 << GAP_BITS) - 1);

  state_t             state_q, state_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic               btn_d;
  logic [N-1:0]       rise_d, press_d;
  logic               toggle;
  logic [LFSR_W-1:0]  lfsr_q;
  logic [GAP_W-1:0]   gap_load;

  bounce_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .clr   (clr),
    .adv   (toggle),
    .state (lfsr_q)
  );

  // Counter holds (gap - 1) so the next toggle lands exactly gap cycles
  // after this one. The gap is drawn from the LFSR value current at the
  // toggle; the LFSR steps on that same edge.
  assign gap_load = GAP_W'(MIN_GAP - 1) + GAP_W'(lfsr_q & GAP_MASK);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= IDLE_LOW;
      button_out  <= 1'b0;
      gap_q       <= '0;
      tog_q       <= '0;
      set_q       <= '0;
      rise_count  <= '0;
      press_count <= '0;
    end else begin
      state_q     <= state_d;
      button_out  <= btn_d;
      gap_q       <= gap_d;
      tog_q       <= tog_d;
      set_q       <= set_d;
      rise_count  <= rise_d;
      press_count <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tog_d   = tog_q;
    set_d   = set_q;
    press_d = press_count;
    toggle  = 1'b0;
    case (state_q)
      IDLE_LOW: if (press_req) begin
        state_d = BOUNCE_RISE;
        toggle  = 1'b1;
        tog_d   = TOG_W'(1);
      end
      STABLE_HIGH: if (!press_req) begin
        state_d = BOUNCE_FALL;
        toggle  = 1'b1;
        tog_d   = TOG_W'(1);
      end
      BOUNCE_RISE, BOUNCE_FALL: begin
        // The final toggle already happened on the previous edge; with no
        // glitches this makes the burst a single toggle then settle.
        if (tog_q == TOG_W'(TOGGLES)) begin
          state_d = (state_q == BOUNCE_RISE) ? SETTLE_HIGH : SETTLE_LOW;
          set_d   = SET_W'(SETTLE - 1);
          tog_d   = '0;
        end else if (gap_q == '0) begin
          toggle = 1'b1;
          tog_d  = tog_q + TOG_W'(1);
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      SETTLE_HIGH, SETTLE_LOW: begin
        if (set_q == '0) begin
          if (state_q == SETTLE_HIGH) begin
            state_d = STABLE_HIGH;
            press_d = press_count + N'(1);
          end else begin
            state_d = IDLE_LOW;
          end
        end else begin
          set_d = set_q - SET_W'(1);
        end
      end
      default: state_d = IDLE_LOW;
    endcase
    if (toggle) gap_d = gap_load;
    btn_d  = button_out ^ toggle;
    rise_d = rise_count + N'(toggle & ~button_out);
  end

  assign busy = (state_q != IDLE_LOW) && (state_q != STABLE_HIGH);

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: one clean-edge instance (GLITCH_PAIRS=0)
// and one glitchy instance (GLITCH_PAIRS=3) sharing clock and reset.
module tb_bounce_generator;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       p0 = 1'b0, p3 = 1'b0;
  logic       b0, busy0, b3, busy3;
  logic [3:0] rc0, pc0, rc3, pc3;

  int   vec = 0;
  int   errs = 0;
  int   iv[8];
  int   ntog;
  logic first_b;
  bit   tout;
  int   rise_ref[6] = '{9, 14, 9, 14, 8, 13};
  int   fall_ref[6];

  always #5 clk = ~clk;

  bounce_generator #(.N(4), .GLITCH_PAIRS(0)) dut0 (
    .clk(clk), .clr(clr), .press_req(p0), .button_out(b0), .busy(busy0),
    .rise_count(rc0), .press_count(pc0)
  );

  bounce_generator #(.N(4), .GLITCH_PAIRS(3)) dut3 (
    .clk(clk), .clr(clr), .press_req(p3), .button_out(b3), .busy(busy3),
    .rise_count(rc3), .press_count(pc3)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle0(output bit to);
    int n = 0;
    while (busy0 && n < 100) begin tick; n++; end
    to = busy0;
  endtask

  // Drive a level change on dut3 and record the spacing of every toggle
  // until the burst and settle phases are over.
  task automatic run_burst3(input logic level, input bit wiggle);
    int cyc, last, k;
    logic prev;
    p3 = level;
    tick;
    first_b = b3; prev = b3; cyc = 0; last = 0; k = 0;
    for (int i = 0; i < 8; i++) iv[i] = 0;
    while (busy3 && cyc < 400) begin
      if (wiggle) p3 = ((cyc % 4) < 2) ? ~level : level;
      tick; cyc++;
      if (b3 !== prev) begin
        if (k < 8) iv[k] = cyc - last;
        k++; last = cyc; prev = b3;
      end
    end
    p3 = level;
    tout = busy3;
    ntog = k + 1;
  endtask

  task automatic test_reset;
    #2 clr = 1'b0;
    #1;
    vec++; if (b0 !== 1'b0)    begin errs++; $display("FAIL reset_b0 got %0b want 0", b0); end
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL reset_busy0 got %0b want 0", busy0); end
    vec++; if (rc0 !== 4'd0)   begin errs++; $display("FAIL reset_rc0 got %0d want 0", rc0); end
    vec++; if (pc0 !== 4'd0)   begin errs++; $display("FAIL reset_pc0 got %0d want 0", pc0); end
    p0 = 1'b1; p3 = 1'b1;
    repeat (3) tick;
    vec++; if (b3 !== 1'b0)    begin errs++; $display("FAIL reset_hold_b3 got %0b want 0", b3); end
    vec++; if (busy3 !== 1'b0) begin errs++; $display("FAIL reset_hold_busy3 got %0b want 0", busy3); end
    p3 = 1'b0;
    @(negedge clk) clr = 1'b1;
  endtask

  task automatic test_clean_press;
    int n;
    bit to;
    tick;
    vec++; if (b0 !== 1'b1)    begin errs++; $display("FAIL clean_first_edge got %0b want 1", b0); end
    vec++; if (rc0 !== 4'd1)   begin errs++; $display("FAIL clean_rc_rise got %0d want 1", rc0); end
    n = 0;
    while (busy0 && n < 100) begin n++; tick; end
    vec++; if (n !== 17)       begin errs++; $display("FAIL clean_busy_len got %0d want 17", n); end
    repeat (22) tick;
    vec++; if (b0 !== 1'b1)    begin errs++; $display("FAIL clean_hold_b0 got %0b want 1", b0); end
    vec++; if (busy0 !== 1'b0) begin errs++; $display("FAIL clean_hold_busy got %0b want 0", busy0); end
    vec++; if (rc0 !== 4'd1)   begin errs++; $display("FAIL clean_rc got %0d want 1", rc0); end
    vec++; if (pc0 !== 4'd1)   begin errs++; $display("FAIL clean_pc got %0d want 1", pc0); end
    p0 = 1'b0;
    tick;
    vec++; if (b0 !== 1'b0)    begin errs++; $display("FAIL clean_release got %0b want 0", b0); end
    wait_idle0(to);
    vec++; if (to !== 1'b0)    begin errs++; $display("FAIL clean_release_timeout got %0b want 0", to); end
    vec++; if (pc0 !== 4'd1 || rc0 !== 4'd1)
      begin errs++; $display("FAIL clean_after_release got pc=%0d rc=%0d want pc=1 rc=1", pc0, rc0); end
  endtask

  task automatic test_wrap;
    bit to, tmo;
    tmo = 1'b0;
    for (int i = 2; i <= 16; i++) begin
      p0 = 1'b1; tick; wait_idle0(to); tmo |= to;
      p0 = 1'b0; tick; wait_idle0(to); tmo |= to;
      if (i == 15) begin
        vec++; if (pc0 !== 4'd15 || rc0 !== 4'd15)
          begin errs++; $display("FAIL wrap_pre got pc=%0d rc=%0d want 15 15", pc0, rc0); end
      end
    end
    vec++; if (tmo !== 1'b0)   begin errs++; $display("FAIL wrap_timeout got %0b want 0", tmo); end
    vec++; if (pc0 !== 4'd0)   begin errs++; $display("FAIL wrap_pc got %0d want 0", pc0); end
    vec++; if (rc0 !== 4'd0)   begin errs++; $display("FAIL wrap_rc got %0d want 0", rc0); end
  endtask

  task automatic test_burst;
    run_burst3(1'b1, 1'b0);
    vec++; if (first_b !== 1'b1) begin errs++; $display("FAIL burst_first_edge got %0b want 1", first_b); end
    vec++; if (tout !== 1'b0)  begin errs++; $display("FAIL burst_rise_timeout got %0b want 0", tout); end
    vec++; if (ntog !== 7)     begin errs++; $display("FAIL burst_rise_toggles got %0d want 7", ntog); end
    for (int i = 0; i < 6; i++) begin
      vec++; if (iv[i] !== rise_ref[i])
        begin errs++; $display("FAIL burst_rise_gap%0d got %0d want %0d", i, iv[i], rise_ref[i]); end
    end
    vec++; if (rc3 !== 4'd4 || pc3 !== 4'd1 || b3 !== 1'b1)
      begin errs++; $display("FAIL burst_rise_end got rc=%0d pc=%0d b=%0b want 4 1 1", rc3, pc3, b3); end
    run_burst3(1'b0, 1'b0);
    vec++; if (ntog !== 7)     begin errs++; $display("FAIL burst_fall_toggles got %0d want 7", ntog); end
    for (int i = 0; i < 6; i++) begin
      fall_ref[i] = iv[i];
      vec++; if (iv[i] < 4 || iv[i] > 19)
        begin errs++; $display("FAIL burst_fall_gap%0d got %0d want 4..19", i, iv[i]); end
    end
    vec++; if (rc3 !== 4'd7 || pc3 !== 4'd1 || b3 !== 1'b0)
      begin errs++; $display("FAIL burst_fall_end got rc=%0d pc=%0d b=%0b want 7 1 0", rc3, pc3, b3); end
  endtask

  task automatic test_midburst_reset;
    int k, cyc, chg;
    logic prev;
    p3 = 1'b1; tick;
    prev = b3; k = 0; cyc = 0;
    while (k < 2 && cyc < 100) begin
      tick; cyc++;
      if (b3 !== prev) begin k++; prev = b3; end
    end
    vec++; if (k !== 2)        begin errs++; $display("FAIL mid_third_toggle got %0d want 2", k); end
    tick;
    #2 clr = 1'b0;
    #1;
    vec++; if (b3 !== 1'b0 || busy3 !== 1'b0)
      begin errs++; $display("FAIL mid_reset_out got b=%0b busy=%0b want 0 0", b3, busy3); end
    vec++; if (rc3 !== 4'd0 || pc3 !== 4'd0)
      begin errs++; $display("FAIL mid_reset_cnt got rc=%0d pc=%0d want 0 0", rc3, pc3); end
    p3 = 1'b0;
    @(negedge clk) clr = 1'b1;
    chg = 0;
    repeat (30) begin tick; if (b3 !== 1'b0 || busy3 !== 1'b0) chg++; end
    vec++; if (chg !== 0)      begin errs++; $display("FAIL mid_no_toggle got %0d want 0", chg); end
  endtask

  task automatic test_repeat_wiggle;
    run_burst3(1'b1, 1'b1);
    vec++; if (ntog !== 7)     begin errs++; $display("FAIL rep_rise_toggles got %0d want 7", ntog); end
    for (int i = 0; i < 6; i++) begin
      vec++; if (iv[i] !== rise_ref[i])
        begin errs++; $display("FAIL rep_rise_gap%0d got %0d want %0d", i, iv[i], rise_ref[i]); end
    end
    repeat (5) tick;
    vec++; if (b3 !== 1'b1 || busy3 !== 1'b0 || rc3 !== 4'd4 || pc3 !== 4'd1)
      begin errs++; $display("FAIL rep_stable got b=%0b busy=%0b rc=%0d pc=%0d want 1 0 4 1", b3, busy3, rc3, pc3); end
    run_burst3(1'b0, 1'b0);
    vec++; if (first_b !== 1'b0) begin errs++; $display("FAIL rep_fall_edge got %0b want 0", first_b); end
    for (int i = 0; i < 6; i++) begin
      vec++; if (iv[i] !== fall_ref[i])
        begin errs++; $display("FAIL rep_fall_gap%0d got %0d want %0d", i, iv[i], fall_ref[i]); end
    end
    vec++; if (rc3 !== 4'd7 || b3 !== 1'b0)
      begin errs++; $display("FAIL rep_fall_end got rc=%0d b=%0b want 7 0", rc3, b3); end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_wrap;
    test_burst;
    test_midburst_reset;
    test_repeat_wiggle;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/bounce_generator.md
BOUNCE_GENERATOR -- requirements
Module: bounce_generator

Interface
REQ-001 Parameter N, default 4, width of the rise_count and press_count counters.
REQ-002 Parameter GLITCH_PAIRS, default 3, number of spurious pulse pairs added to each bounce burst (0 gives a clean edge).
REQ-003 Parameter MIN_GAP, default 4, minimum number of cycles between consecutive toggles in a burst (at least 1).
REQ-004 Parameter GAP_BITS, default 4, number of LFSR bits that form the random part of each gap (at most 8).
REQ-005 Parameter SETTLE, default 16, number of cycles the final level is held after a burst (at least 1).
REQ-006 Parameter LFSR_SEED, default 8'hA5, LFSR reset value (nonzero).
REQ-007 clk  input  1  the single clock; all state changes on its rising edge.
REQ-008 clr  input  1  reset, asynchronous and active-low.
REQ-009 press_req  input  1  requested button level, synchronous to clk.
REQ-010 button_out  output  1  emulated bouncy button level, registered.
REQ-011 busy  output  1  high while a burst or settle phase is in progress.
REQ-012 rise_count  output  N  count of rising edges on button_out, wraps modulo 2^N.
REQ-013 press_count  output  N  count of completed clean presses, wraps modulo 2^N.

Function
REQ-014 The FSM SHALL have the states IDLE_LOW, BOUNCE_RISE, SETTLE_HIGH, STABLE_HIGH, BOUNCE_FALL and SETTLE_LOW.
REQ-015 press_req SHALL be sampled only in IDLE_LOW and STABLE_HIGH; changes during any other state are ignored.
REQ-016 IDLE_LOW with press_req=1 SHALL enter BOUNCE_RISE; button_out SHALL go to 1 on that same edge (one-cycle latency from sampling).
REQ-017 Each burst SHALL produce exactly 2*GLITCH_PAIRS+1 toggles of button_out and SHALL end at the target level.
REQ-018 The gap between consecutive toggles SHALL be MIN_GAP + lfsr[GAP_BITS-1:0] cycles, which lies in [MIN_GAP, MIN_GAP+2^GAP_BITS-1].
REQ-019 The LFSR SHALL be 8-bit Fibonacci with taps x^8+x^6+x^5+x^4+1 and SHALL advance only on each toggle, so the sequence is deterministic from reset.
REQ-020 After the final toggle of a burst, the FSM SHALL hold the level for SETTLE cycles in SETTLE_HIGH or SETTLE_LOW, then enter STABLE_HIGH or IDLE_LOW respectively.
REQ-021 STABLE_HIGH with press_req=0 SHALL enter BOUNCE_FALL, mirroring REQ-016 to REQ-020 with the target level 0.
REQ-022 busy SHALL be 1 in the BOUNCE and SETTLE states and 0 in IDLE_LOW and STABLE_HIGH.
REQ-023 rise_count SHALL increment on every 0-to-1 transition of button_out, glitch edges included.
REQ-024 press_count SHALL increment once on the transition SETTLE_HIGH to STABLE_HIGH.
REQ-025 Both counters SHALL wrap from 2^N-1 to 0 with no saturation and no flag.
REQ-026 With GLITCH_PAIRS=0 a burst SHALL be a single toggle followed directly by the settle phase.

Reset
REQ-027 When clr=0 the block SHALL asynchronously set: state to IDLE_LOW, button_out to 0, busy to 0, rise_count to 0, press_count to 0, LFSR to LFSR_SEED, and the gap and toggle counters to 0.
REQ-028 Reset asserted mid-burst or mid-settle SHALL abort the burst immediately, with no further toggles.
REQ-029 After clr deasserts, the first press_req sample SHALL occur on the first rising clk edge.

Structure
REQ-030 The state enumeration, LFSR width, tap constants and default seed SHALL live in a shared package, bounce_pkg.
REQ-031 The LFSR SHALL be a separate sub-module, bounce_lfsr, with clk, clr, an advance enable, a seed parameter and an 8-bit state output.
REQ-032 The gap counter SHALL be $clog2(MIN_GAP+2^GAP_BITS) bits wide, and the toggle counter SHALL be sized for 2*GLITCH_PAIRS+1.

Verification
REQ-033 GLITCH_PAIRS=0, press_req held 1 for 40 cycles -> button_out=1 one cycle after sampling; busy high for 1+SETTLE cycles; rise_count=1; press_count=1.
REQ-034 GLITCH_PAIRS=3, one press then one release -> 7 toggles per burst; rise_count=4 after the press, 7 after the release; press_count=1.
REQ-035 GLITCH_PAIRS=3, check every toggle interval -> each interval lies in [4,19], and the interval sequence is identical across two runs from reset.
REQ-036 N=4, GLITCH_PAIRS=0, 16 press/release cycles -> press_count wraps to 0 and rise_count wraps to 0.
REQ-037 press_req toggled every 2 cycles during a burst -> the burst completes unchanged, and the new level is sampled only in the stable state.
REQ-038 clr pulsed low after the third toggle of a burst -> button_out=0, counters=0, state IDLE_LOW, LFSR=8'hA5; the next press reproduces the first-run gaps.
